// File: rtl/matmul_result_drain.sv
// Captures row-major matmul results into local storage, then streams them in address order
// over valid/ready with row/col tags, a last flag and optional ReLU.
module matmul_result_drain #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024,
    parameter bit RELU   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [9:0]        m,
    input  logic [9:0]        n,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              mm_done,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [9:0]        out_row,
    output logic [9:0]        out_col,
    output logic              out_last,
    output logic              busy,
    output logic              drain_done,
    output logic              err
);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, FINISH} state_t;
    state_t state;

    logic [19:0]       total, count, rd_idx, prod, count_next;
    logic [9:0]        n_reg, rd_row, rd_col;
    logic              wr_ok, fire, rd_issue, room;
    logic [1:0]        occ;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data, pend_word;
    logic              rd_pending, pend_last;
    logic [9:0]        pend_row, pend_col;
    logic              skid_valid, skid_last;
    logic [DATA_W-1:0] skid_data;
    logic [9:0]        skid_row, skid_col;

    assign prod       = {10'd0, m} * {10'd0, n};
    assign wr_ok      = (state == CAPTURE) && wr_en && (32'(wr_addr) < 32'(total));
    assign count_next = count + 20'(wr_ok);
    assign fire       = out_valid && out_ready;
    assign pend_word  = (RELU && rd_data[DATA_W-1]) ? '0 : rd_data;

    // Output register plus skid give two slots; a read is only issued when the word it
    // returns next cycle is guaranteed a slot, which sustains one transfer per cycle.
    assign occ      = 2'(out_valid) + 2'(skid_valid) + 2'(rd_pending);
    assign room     = (occ < 2'd2) || ((occ == 2'd2) && fire);
    assign rd_issue = (state == DRAIN) && (rd_idx < total) && room;

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[MEM_AW'(wr_addr)] <= wr_data;
        if (rd_issue)
            rd_data <= mem[MEM_AW'(rd_idx)];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            total      <= '0;
            count      <= '0;
            n_reg      <= '0;
            rd_idx     <= '0;
            rd_row     <= '0;
            rd_col     <= '0;
            rd_pending <= 1'b0;
            pend_row   <= '0;
            pend_col   <= '0;
            pend_last  <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_row   <= '0;
            skid_col   <= '0;
            skid_last  <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            drain_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        total <= prod;
                        n_reg <= n;
                        count <= '0;
                        busy  <= 1'b1;
                        if (prod == 20'd0 || {12'd0, prod} > 32'(DEPTH)) begin
                            err        <= 1'b1;
                            drain_done <= 1'b1;
                            state      <= FINISH;
                        end else begin
                            err   <= 1'b0;
                            state <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (wr_en && !wr_ok)
                        err <= 1'b1;
                    count <= count_next;
                    if (mm_done) begin
                        // A write landing together with mm_done is part of the count.
                        if (count_next != total)
                            err <= 1'b1;
                        rd_idx <= '0;
                        rd_row <= '0;
                        rd_col <= '0;
                        state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    rd_pending <= rd_issue;
                    if (rd_issue) begin
                        rd_idx    <= rd_idx + 20'd1;
                        pend_row  <= rd_row;
                        pend_col  <= rd_col;
                        pend_last <= (rd_idx == total - 20'd1);
                        if (rd_col == n_reg - 10'd1) begin
                            rd_col <= '0;
                            rd_row <= rd_row + 10'd1;
                        end else begin
                            rd_col <= rd_col + 10'd1;
                        end
                    end
                    if (fire) begin
                        if (skid_valid) begin
                            out_data   <= skid_data;
                            out_row    <= skid_row;
                            out_col    <= skid_col;
                            out_last   <= skid_last;
                            skid_valid <= rd_pending;
                            skid_data  <= pend_word;
                            skid_row   <= pend_row;
                            skid_col   <= pend_col;
                            skid_last  <= pend_last;
                        end else if (rd_pending) begin
                            out_data <= pend_word;
                            out_row  <= pend_row;
                            out_col  <= pend_col;
                            out_last <= pend_last;
                        end else begin
                            out_valid <= 1'b0;
                        end
                    end else if (rd_pending) begin
                        if (!out_valid) begin
                            out_valid <= 1'b1;
                            out_data  <= pend_word;
                            out_row   <= pend_row;
                            out_col   <= pend_col;
                            out_last  <= pend_last;
                        end else begin
                            skid_valid <= 1'b1;
                            skid_data  <= pend_word;
                            skid_row   <= pend_row;
                            skid_col   <= pend_col;
                            skid_last  <= pend_last;
                        end
                    end
                    if (fire && out_last) begin
                        out_valid  <= 1'b0;
                        skid_valid <= 1'b0;
                        rd_pending <= 1'b0;
                        drain_done <= 1'b1;
                        state      <= FINISH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_result_drain.sv
// Drives a RELU=0 and a RELU=1 instance with identical stimulus and checks both streams
// against an address-indexed reference memory and the row/col/last arithmetic.
module tb_matmul_result_drain;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [9:0]    m = '0;
    logic [9:0]    n = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic          mm_done = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data [2];
    logic          out_valid [2];
    logic [9:0]    out_row [2];
    logic [9:0]    out_col [2];
    logic          out_last [2];
    logic          busy [2];
    logic          drain_done [2];
    logic          err [2];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        matmul_result_drain #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RELU(gi == 1)) dut (
            .clk(clk), .rst_n(rst_n), .start(start), .m(m), .n(n),
            .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .mm_done(mm_done),
            .out_data(out_data[gi]), .out_valid(out_valid[gi]), .out_ready(out_ready),
            .out_row(out_row[gi]), .out_col(out_col[gi]), .out_last(out_last[gi]),
            .busy(busy[gi]), .drain_done(drain_done[gi]), .err(err[gi])
        );
    end

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    bit          model_known [DEPTH];
    int          cur_total = 0;
    int          cur_n = 1;

    typedef struct {
        int m;
        int n;
        bit exp_err;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string tag, input bit v, input bit b, input bit dd, input bit e);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s[%0d] out_valid", tag, d), 64'(out_valid[d]), 64'(v));
            chk($sformatf("%s[%0d] busy", tag, d), 64'(busy[d]), 64'(b));
            chk($sformatf("%s[%0d] drain_done", tag, d), 64'(drain_done[d]), 64'(dd));
            chk($sformatf("%s[%0d] err", tag, d), 64'(err[d]), 64'(e));
        end
    endtask

    task automatic chk_err(input string tag, input bit e);
        for (int d = 0; d < 2; d++)
            chk($sformatf("%s[%0d] err", tag, d), 64'(err[d]), 64'(e));
    endtask

    function automatic logic [31:0] exp_word(input int k, input int d);
        logic [31:0] raw;
        raw = model_mem[k];
        return (d == 1 && raw[31]) ? 32'd0 : raw;
    endfunction

    task automatic do_start(input int mm, input int nn);
        m = 10'(mm);
        n = 10'(nn);
        start = 1'b1;
        step();
        start = 1'b0;
        cur_total = mm * nn;
        cur_n = nn;
    endtask

    task automatic do_write(input int addr, input logic [31:0] d, input bit done);
        wr_en = 1'b1;
        wr_addr = AW'(addr);
        wr_data = d;
        mm_done = done;
        step();
        wr_en = 1'b0;
        mm_done = 1'b0;
        if (addr < cur_total) begin
            model_mem[addr] = d;
            model_known[addr] = 1'b1;
        end
        $display("write addr=%0d data=%0h done=%0b", addr, d, done);
    endtask

    task automatic pulse_done();
        mm_done = 1'b1;
        step();
        mm_done = 1'b0;
    endtask

    // Called at the first sample point after the DRAIN-entry edge.
    // mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: random ready.
    task automatic drain(input string tag, input int mode, input int stop_after);
        int k = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        while (k < stop_after && cyc < 8 * cur_total + 20) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            for (int d = 0; d < 2; d++) begin
                if (cyc < 2)
                    chk($sformatf("%s[%0d] early_valid c%0d", tag, d, cyc), 64'(out_valid[d]), 64'd0);
                else if (cyc == 2 || mode == 0 || stalled)
                    chk($sformatf("%s[%0d] valid c%0d", tag, d, cyc), 64'(out_valid[d]), 64'd1);
                if (out_valid[d]) begin
                    if (model_known[k])
                        chk($sformatf("%s[%0d] data k%0d", tag, d, k), 64'(out_data[d]), 64'(exp_word(k, d)));
                    chk($sformatf("%s[%0d] row k%0d", tag, d, k), 64'(out_row[d]), 64'(k / cur_n));
                    chk($sformatf("%s[%0d] col k%0d", tag, d, k), 64'(out_col[d]), 64'(k % cur_n));
                    chk($sformatf("%s[%0d] last k%0d", tag, d, k), 64'(out_last[d]), 64'(k == cur_total - 1));
                end
            end
            stalled = out_valid[0] && !out_ready;
            if (out_valid[0] && out_ready) begin
                $display("xfer %s k=%0d row=%0d col=%0d data=%0h/%0h last=%0b", tag, k,
                         out_row[0], out_col[0], out_data[0], out_data[1], out_last[0]);
                k++;
            end
            step();
            cyc++;
        end
        chk({tag, " transfers"}, 64'(k), 64'(stop_after));
        if (stop_after == cur_total) begin
            chk_status({tag, " finish"}, 1'b0, 1'b1, 1'b1, err[0]);
            step();
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("%s[%0d] idle busy", tag, d), 64'(busy[d]), 64'd0);
                chk($sformatf("%s[%0d] idle drain_done", tag, d), 64'(drain_done[d]), 64'd0);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic run_2x3(input string tag, input int mode);
        do_start(2, 3);
        chk_status({tag, " armed"}, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int a = 0; a < 6; a++)
            do_write(a, 32'(10 + a), 1'b0);
        pulse_done();
        drain(tag, mode, 6);
        chk_err({tag, " end"}, 1'b0);
    endtask

    initial begin
        int addrs[$];
        int tot;
        bit joint;
        int j;
        int tmp;
        logic [31:0] v;

        vecs[0] = '{m: 2,  n: 3,  exp_err: 1'b0};
        vecs[1] = '{m: 0,  n: 5,  exp_err: 1'b1};
        vecs[2] = '{m: 1,  n: 1,  exp_err: 1'b0};
        vecs[3] = '{m: 32, n: 33, exp_err: 1'b1};
        vecs[4] = '{m: 7,  n: 0,  exp_err: 1'b1};
        vecs[5] = '{m: 3,  n: 17, exp_err: 1'b0};
        vecs[6] = '{m: 32, n: 32, exp_err: 1'b0};
        vecs[7] = '{m: 10, n: 10, exp_err: 1'b0};

        step();
        step();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset[%0d] out_data", d), 64'(out_data[d]), 64'd0);
            chk($sformatf("reset[%0d] out_row", d), 64'(out_row[d]), 64'd0);
            chk($sformatf("reset[%0d] out_col", d), 64'(out_col[d]), 64'd0);
            chk($sformatf("reset[%0d] out_last", d), 64'(out_last[d]), 64'd0);
        end
        chk_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();

        run_2x3("basic", 0);
        run_2x3("stall", 1);

        do_start(1, 4);
        do_write(0, 32'hFFFF_FFFB, 1'b0);
        do_write(1, 32'd0, 1'b0);
        do_write(2, 32'd7, 1'b0);
        do_write(3, 32'hFFFF_FFFF, 1'b0);
        pulse_done();
        drain("relu", 0, 4);

        // Out-of-range write plus short count: err, but the stream still runs.
        do_start(2, 2);
        do_write(0, $urandom, 1'b0);
        do_write(1, $urandom, 1'b0);
        do_write(4, 32'h1234_5678, 1'b0);
        chk_err("badaddr write", 1'b1);
        do_write(2, $urandom, 1'b0);
        pulse_done();
        chk_err("badaddr done", 1'b1);
        drain("badaddr", 2, 4);
        chk_err("badaddr end", 1'b1);

        // Write in IDLE is ignored; start during CAPTURE is ignored; rewrites count.
        wr_en = 1'b1;
        wr_addr = '0;
        wr_data = 32'hDEAD_BEEF;
        step();
        wr_en = 1'b0;
        chk_err("idle write", 1'b1);
        do_start(1, 2);
        chk_status("rearm", 1'b0, 1'b1, 1'b0, 1'b0);
        v = $urandom;
        wr_en = 1'b1;
        wr_addr = 16'd1;
        wr_data = v;
        start = 1'b1;
        m = 10'd5;
        n = 10'd5;
        step();
        start = 1'b0;
        wr_en = 1'b0;
        model_mem[1] = v;
        model_known[1] = 1'b1;
        do_write(1, $urandom, 1'b1);
        chk_err("rewrite done", 1'b0);
        drain("rewrite", 0, 2);

        for (int i = 0; i < 8; i++) begin
            do_start(vecs[i].m, vecs[i].n);
            tot = vecs[i].m * vecs[i].n;
            if (vecs[i].exp_err) begin
                chk_status($sformatf("vec%0d reject", i), 1'b0, 1'b1, 1'b1, 1'b1);
                step();
                chk_status($sformatf("vec%0d after", i), 1'b0, 1'b0, 1'b0, 1'b1);
                $display("vec%0d m=%0d n=%0d rejected", i, vecs[i].m, vecs[i].n);
            end else begin
                chk_status($sformatf("vec%0d armed", i), 1'b0, 1'b1, 1'b0, 1'b0);
                addrs.delete();
                for (int a = 0; a < tot; a++)
                    addrs.push_back(a);
                for (int a = tot - 1; a > 0; a--) begin
                    j = $urandom_range(0, a);
                    tmp = addrs[a];
                    addrs[a] = addrs[j];
                    addrs[j] = tmp;
                end
                joint = 1'($urandom_range(0, 1));
                for (int a = 0; a < tot; a++) begin
                    if ($urandom_range(0, 3) == 0)
                        step();
                    do_write(addrs[a], $urandom, joint && (a == tot - 1));
                end
                if (!joint)
                    pulse_done();
                chk_err($sformatf("vec%0d done", i), 1'b0);
                drain($sformatf("vec%0d", i), 2, tot);
                chk_err($sformatf("vec%0d end", i), 1'b0);
            end
        end

        // Asynchronous reset in the middle of a stream.
        do_start(2, 3);
        for (int a = 0; a < 6; a++)
            do_write(a, $urandom, 1'b0);
        pulse_done();
        drain("abort", 0, 2);
        rst_n = 1'b0;
        #1;
        chk_status("abort reset", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        run_2x3("post_reset", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
